// File: rtl/sdr_rx_pkg.sv
// Shared definitions for the SDR receive path: alignment FSM states,
// beat packing order and the channel-count legality check.
package sdr_rx_pkg;

  // Alignment FSM states; LOCKED doubles as the `locked` status bit.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_e;

  // Packing order inside one channel lane: I in the low half, Q above it.
  localparam int COMP_I       = 0;
  localparam int COMP_Q       = 1;
  localparam int COMPS_PER_CH = 2;
  localparam int MAX_NUM_CH   = 2;

  // Only one or two channels per frame group are supported.
  function automatic logic num_ch_legal(input int n);
    return (n >= 1) && (n <= MAX_NUM_CH);
  endfunction

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second clock edge after the async reset falls. Output is active-low.
module reset_sync_2ff (
  input  logic clk,
  input  logic arst,
  output logic rst_n_out
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift a constant one through the chain after release.
  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  // Synchroniser flops; cleared immediately by the async reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_out = sync_q[1];

endmodule

// File: rtl/ad9361_rx_ingest.sv
// AD9361 receive ingest: frame alignment, channel demux, sign extension
// and a single-entry AXI-Stream output register that drops new groups
// under backpressure. Optional macro RX_INGEST_STATS_EN enables the
// saturating drop / frame-error counters; otherwise they read as zero.
module ad9361_rx_ingest
  import sdr_rx_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int OUT_W    = 16,
  parameter int NUM_CH   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                         AD9361_CLK,
  input  logic                         rst_32d768M,
  output logic                         aresetn_out,
  input  logic                         in_valid,
  input  logic                         in_frame,
  input  logic [SAMPLE_W-1:0]          in_i,
  input  logic [SAMPLE_W-1:0]          in_q,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [NUM_CH*2*OUT_W-1:0]    m_axis_tdata,
  output logic                         locked,
  output logic                         ovf_sticky,
  output logic [CNT_W-1:0]             ovf_cnt,
  output logic [CNT_W-1:0]             ferr_cnt
);

  localparam int          GRP_W    = NUM_CH * COMPS_PER_CH * OUT_W;
  localparam logic [0:0]  LAST_IDX = 1'(NUM_CH - 1);

  if (!num_ch_legal(NUM_CH)) begin : g_bad_num_ch
    $error("ad9361_rx_ingest: NUM_CH must be 1 or 2");
  end
  if (OUT_W < SAMPLE_W) begin : g_bad_out_w
    $error("ad9361_rx_ingest: OUT_W must be >= SAMPLE_W");
  end

  logic aresetn_s;
  logic arst_s;

  reset_sync_2ff u_rst_sync (
    .clk       (AD9361_CLK),
    .arst      (rst_32d768M),
    .rst_n_out (aresetn_s)
  );

  assign aresetn_out = aresetn_s;
  assign arst_s      = ~aresetn_s;

  align_state_e          state_q, state_d;
  logic [0:0]            idx_q, idx_d;
  logic [SAMPLE_W-1:0]   ch0_i_q, ch0_i_d, ch0_q_q, ch0_q_d;
  logic                  tvalid_q, tvalid_d;
  logic [GRP_W-1:0]      tdata_q, tdata_d;
  logic                  sticky_q, sticky_d;
  logic                  grp_done_s;
  logic                  load_s;
  logic                  drop_s;
  logic [GRP_W-1:0]      grp_s;
  logic [SAMPLE_W-1:0]   lane_i_s, lane_q_s;
`ifdef RX_INGEST_STATS_EN
  logic                  ferr_s;
`endif

  // Alignment FSM: track channel index, buffer ch0, flag completion/errors.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ch0_i_d    = ch0_i_q;
    ch0_q_d    = ch0_q_q;
    grp_done_s = 1'b0;
`ifdef RX_INGEST_STATS_EN
    ferr_s     = 1'b0;
`endif
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_frame) begin
            ch0_i_d    = in_i;
            ch0_q_d    = in_q;
            state_d    = LOCKED;
            idx_d      = LAST_IDX;
            grp_done_s = (LAST_IDX == 1'b0);
          end else begin
            state_d = HUNT;
            idx_d   = 1'b0;
          end
        end
        LOCKED: begin
          if (in_frame == (idx_q == 1'b0)) begin
            if (idx_q == LAST_IDX) begin
              grp_done_s = 1'b1;
              idx_d      = 1'b0;
            end else begin
              ch0_i_d = in_i;
              ch0_q_d = in_q;
              idx_d   = idx_q + 1'b1;
            end
          end else begin
`ifdef RX_INGEST_STATS_EN
            ferr_s = 1'b1;
`endif
            if (in_frame) begin
              // Start of a new frame mid-group: restart with this word as ch0.
              ch0_i_d = in_i;
              ch0_q_d = in_q;
              state_d = LOCKED;
              idx_d   = LAST_IDX;
            end else begin
              state_d = HUNT;
              idx_d   = 1'b0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Assemble the sign-extended group; the last channel comes from the live word.
  always_comb begin
    grp_s    = '0;
    lane_i_s = '0;
    lane_q_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == NUM_CH - 1) begin
        lane_i_s = in_i;
        lane_q_s = in_q;
      end else begin
        lane_i_s = ch0_i_q;
        lane_q_s = ch0_q_q;
      end
      grp_s[(COMPS_PER_CH*c + COMP_I)*OUT_W +: OUT_W] = OUT_W'($signed(lane_i_s));
      grp_s[(COMPS_PER_CH*c + COMP_Q)*OUT_W +: OUT_W] = OUT_W'($signed(lane_q_s));
    end
  end

  assign load_s = grp_done_s & (~tvalid_q | m_axis_tready);
  assign drop_s = grp_done_s & tvalid_q & ~m_axis_tready;

  // Output register: load when empty or draining, otherwise keep the held beat.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    sticky_d = sticky_q | drop_s;
    if (load_s) begin
      tvalid_d = 1'b1;
      tdata_d  = grp_s;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // State flops, held in reset until the synchronised reset releases.
  always_ff @(posedge AD9361_CLK or posedge arst_s) begin
    if (arst_s) begin
      state_q  <= HUNT;
      idx_q    <= 1'b0;
      ch0_i_q  <= '0;
      ch0_q_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ch0_i_q  <= ch0_i_d;
      ch0_q_q  <= ch0_q_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef RX_INGEST_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d, ferr_cnt_q, ferr_cnt_d;

  // Saturating drop and frame-error counters.
  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    ferr_cnt_d = ferr_cnt_q;
    if (drop_s && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
    if (ferr_s && (ferr_cnt_q != CNT_MAX)) begin
      ferr_cnt_d = ferr_cnt_q + CNT_W'(1);
    end else begin
      ferr_cnt_d = ferr_cnt_q;
    end
  end

  // Counter flops.
  always_ff @(posedge AD9361_CLK or posedge arst_s) begin
    if (arst_s) begin
      ovf_cnt_q  <= '0;
      ferr_cnt_q <= '0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  assign ovf_cnt  = ovf_cnt_q;
  assign ferr_cnt = ferr_cnt_q;
`else
  assign ovf_cnt  = '0;
  assign ferr_cnt = '0;
`endif

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign ovf_sticky    = sticky_q;
  assign locked        = (state_q == LOCKED);

endmodule

// File: tb/tb_ad9361_rx_ingest.sv
// Scoreboard bench for ad9361_rx_ingest (NUM_CH=2, CNT_W=4). The stimulus
// side feeds a word-list reference model that pushes expected beats; a
// negedge monitor pops and compares whenever the DUT presents a beat.
module tb_ad9361_rx_ingest;

  localparam int SW = 12;
  localparam int OW = 16;
  localparam int NC = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef RX_INGEST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aresetn_out;
  logic              in_valid = 1'b0;
  logic              in_frame = 1'b0;
  logic [SW-1:0]     in_i = '0;
  logic [SW-1:0]     in_q = '0;
  logic              tvalid;
  logic              tready = 1'b0;
  logic [NC*2*OW-1:0] tdata;
  logic              locked;
  logic              ovf_sticky;
  logic [CW-1:0]     ovf_cnt;
  logic [CW-1:0]     ferr_cnt;

  ad9361_rx_ingest #(.SAMPLE_W(SW), .OUT_W(OW), .NUM_CH(NC), .CNT_W(CW)) dut (
    .AD9361_CLK    (clk),
    .rst_32d768M   (rst),
    .aresetn_out   (aresetn_out),
    .in_valid      (in_valid),
    .in_frame      (in_frame),
    .in_i          (in_i),
    .in_q          (in_q),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .locked        (locked),
    .ovf_sticky    (ovf_sticky),
    .ovf_cnt       (ovf_cnt),
    .ferr_cnt      (ferr_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit              m_locked;
  logic [2*SW-1:0] pend[$];
  bit              m_hv;
  bit              m_sticky;
  int              m_ovf;
  int              m_ferr;
  logic [63:0]     exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] sext(input logic [SW-1:0] x);
    int v;
    v = int'(x);
    if (v >= (1 << (SW - 1))) v = v - (1 << SW);
    return OW'(v);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    pend.delete();
    m_hv     = 1'b0;
    m_sticky = 1'b0;
    m_ovf    = 0;
    m_ferr   = 0;
    exp_q.delete();
  endtask

  // Apply the rules to the inputs that were present at the clock edge just past.
  task automatic model_edge();
    bit          done;
    logic [63:0] grp;
    logic [2*SW-1:0] w;
    done = 1'b0;
    grp  = '0;
    if (in_valid) begin
      if (in_frame) begin
        if (m_locked && pend.size() != 0) m_ferr = sat_inc(m_ferr);
        pend.delete();
        pend.push_back({in_q, in_i});
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (pend.size() == 0) begin
          m_ferr   = sat_inc(m_ferr);
          m_locked = 1'b0;
        end else begin
          pend.push_back({in_q, in_i});
        end
      end
      if (pend.size() == NC) begin
        done = 1'b1;
        for (int c = 0; c < NC; c++) begin
          w = pend[c];
          grp[c*2*OW +: OW]      = sext(w[SW-1:0]);
          grp[c*2*OW + OW +: OW] = sext(w[2*SW-1:SW]);
        end
        pend.delete();
      end
    end
    if (done) begin
      if (!m_hv || tready) begin
        exp_q.push_back(grp);
        m_hv = 1'b1;
      end else begin
        m_ovf    = sat_inc(m_ovf);
        m_sticky = 1'b1;
      end
    end else if (m_hv && tready) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic cycle(input bit v, input bit f, input logic [SW-1:0] i,
                       input logic [SW-1:0] q, input bit r);
    @(posedge clk);
    #1;
    model_edge();
    in_valid = v;
    in_frame = f;
    in_i     = i;
    in_q     = q;
    tready   = r;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    chk({tag, "_tdata"}, tdata, 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_sticky"}, 64'(ovf_sticky), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_cnt), 64'd0);
    chk({tag, "_ferr"}, 64'(ferr_cnt), 64'd0);
  endtask

  task automatic reset_seq();
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    in_valid = 1'b0;
    in_frame = 1'b0;
    tready   = 1'b0;
    model_reset();
    chk("rst_aresetn", 64'(aresetn_out), 64'd0);
    chk_zero("rst_async");
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_aresetn", 64'(aresetn_out), 64'd0);
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_edge1_aresetn", 64'(aresetn_out), 64'd0);
    chk_zero("rel_edge1");
    @(posedge clk);
    #1;
    chk("rel_edge2_aresetn", 64'(aresetn_out), 64'd1);
    mon_en = 1'b1;
  endtask

  // Monitor: compare status against the model and pop beats as they are taken.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("locked", 64'(locked), 64'(m_locked));
      chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
      chk("ovf_cnt", 64'(ovf_cnt), STATS ? 64'(m_ovf) : 64'd0);
      chk("ferr_cnt", 64'(ferr_cnt), STATS ? 64'(m_ferr) : 64'd0);
      chk("tvalid", 64'(tvalid), 64'(m_hv));
      if (tvalid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL beat_unexpected: got %0h expected no beat", tdata);
        end else begin
          chk("tdata", tdata, exp_q[0]);
          if (tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_seq();

    // Two-channel alignment with extreme sample values.
    cycle(1'b1, 1'b1, 12'h7FF, 12'h800, 1'b1);
    cycle(1'b1, 1'b0, 12'h001, 12'hFFF, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    chk("align_tdata", tdata, 64'hFFFF_0001_F800_07FF);
    chk("align_tvalid", 64'(tvalid), 64'd1);
    chk("align_locked", 64'(locked), 64'd1);
    repeat (2) cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);

    // Frame error at index 1: new frame word becomes ch0.
    cycle(1'b1, 1'b1, 12'h123, 12'h456, 1'b1);
    cycle(1'b1, 1'b1, 12'h9AB, 12'hCDE, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    chk("ferr_cnt_one", 64'(ferr_cnt), STATS ? 64'd1 : 64'd0);
    chk("ferr_no_beat", 64'(tvalid), 64'd0);
    chk("ferr_locked", 64'(locked), 64'd1);
    cycle(1'b1, 1'b0, 12'h0F0, 12'hF0F, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);

    // Backpressure: three groups with tready low.
    for (int g = 0; g < 3; g++) begin
      cycle(1'b1, 1'b1, SW'(12'h100 + g), SW'(12'h200 + g), 1'b0);
      cycle(1'b1, 1'b0, SW'(12'h300 + g), SW'(12'h400 + g), 1'b0);
    end
    cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("bp_ovf_cnt", 64'(ovf_cnt), STATS ? 64'd2 : 64'd0);
    chk("bp_sticky", 64'(ovf_sticky), 64'd1);
    chk("bp_held", tdata, 64'h0400_0300_0200_0100);
    repeat (3) cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);

    // Saturation: 21 groups with tready low gives 20 further drops.
    for (int g = 0; g < 21; g++) begin
      cycle(1'b1, 1'b1, SW'($urandom), SW'($urandom), 1'b0);
      cycle(1'b1, 1'b0, SW'($urandom), SW'($urandom), 1'b0);
    end
    cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("sat_ovf_cnt", 64'(ovf_cnt), STATS ? 64'(CNT_MAX) : 64'd0);
    chk("sat_held_valid", 64'(tvalid), 64'd1);

    // Reset mid-beat and mid-group: everything held is lost.
    cycle(1'b1, 1'b1, 12'h555, 12'hAAA, 1'b0);
    reset_seq();
    cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    cycle(1'b1, 1'b0, 12'h111, 12'h222, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    chk("post_rst_hunt", 64'(locked), 64'd0);

    // Randomised traffic, mostly well framed, random backpressure.
    for (int n = 0; n < 2000; n++) begin
      bit v, f, r;
      v = ($urandom_range(9) < 7);
      if ($urandom_range(9) == 0) f = 1'($urandom);
      else f = (pend.size() == 0);
      r = ($urandom_range(9) < 7);
      cycle(v, f, SW'($urandom), SW'($urandom), r);
    end

    // Drain the output register.
    for (int n = 0; n < 20; n++) begin
      cycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
